bsg_dfi_fifo_error_monitor: RTL

- Watches the push/pop handshakes of the AXI-side DFI bridge FIFO and produces the error flag consumed by the DFI clock gate stage (its axi_fifo_error input).
- Tracks FIFO occupancy and flags overflow, underflow and, optionally, stalled-drain timeout.
- Holds the error sticky through a software clear and a hold-off window so the downstream gate samples it on at least one DFI edge.
- Sits entirely in the AXI clock domain.

---
 rtl/bsg_dfi_fifo_mon_pkg.sv | 17 +
 rtl/bsg_dfi_fifo_mon_watchdog.sv | 34 +++
 rtl/bsg_dfi_fifo_error_monitor.sv | 118 +++++++++++
 3 files changed

// File: rtl/bsg_dfi_fifo_mon_pkg.sv
// Shared types for the DFI bridge FIFO error monitor: FSM states and latched error cause.
package bsg_dfi_fifo_mon_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_ERROR   = 2'd1,
    ST_HOLDOFF = 2'd2
  } mon_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE      = 2'd0,
    CAUSE_OVERFLOW  = 2'd1,
    CAUSE_UNDERFLOW = 2'd2,
    CAUSE_TIMEOUT   = 2'd3
  } mon_cause_e;

endpackage

// File: rtl/bsg_dfi_fifo_mon_watchdog.sv
// Stalled-drain watchdog: counts consecutive active cycles and flags expiry on the
// timeout_p-th one. Only instantiated when BSG_DFI_FIFO_MON_TIMEOUT_EN is defined.
module bsg_dfi_fifo_mon_watchdog #(
  parameter int timeout_p = 1024
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic active_i,
  input  logic kick_i,
  output logic expired_o
);

  localparam int cnt_w = (timeout_p > 1) ? $clog2(timeout_p) : 1;
  localparam logic [cnt_w-1:0] last_lp = cnt_w'(timeout_p - 1);

  logic [cnt_w-1:0] cnt_q, cnt_d;
  logic             run;

  assign run       = active_i & ~kick_i;
  assign expired_o = run & (cnt_q == last_lp);

  // Saturate at the terminal value so a persisting stall can never wrap and re-arm.
  always_comb begin
    cnt_d = cnt_q;
    if (!run)                 cnt_d = '0;
    else if (cnt_q != last_lp) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bsg_dfi_fifo_error_monitor.sv
// Occupancy tracker and sticky error flag for the AXI-side DFI bridge FIFO.
// Define BSG_DFI_FIFO_MON_TIMEOUT_EN to add the stalled-drain watchdog (cause 3).
module bsg_dfi_fifo_error_monitor
  import bsg_dfi_fifo_mon_pkg::*;
#(
  parameter int els_p           = 16,
  parameter int holdoff_p       = 32,
  parameter int timeout_p       = 1024,
  parameter int err_cnt_width_p = 8
) (
  input  logic                         axi_clk_i,
  input  logic                         axi_reset_n_i,
  input  logic                         enq_i,
  input  logic                         deq_i,
  input  logic                         flush_i,
  input  logic                         clear_i,
  output logic                         error_o,
  output logic [1:0]                   cause_o,
  output logic [$clog2(els_p+1)-1:0]   count_o,
  output logic [err_cnt_width_p-1:0]   err_cnt_o
);

  localparam int cnt_w  = $clog2(els_p + 1);
  localparam int hold_w = $clog2(holdoff_p + 1);
  localparam logic [cnt_w-1:0]  full_lp = cnt_w'(els_p);
  localparam logic [hold_w-1:0] hold_lp = hold_w'(holdoff_p - 1);

  mon_state_e                 state_q;
  mon_cause_e                 cause_q, det_cause;
  logic                       error_q;
  logic [cnt_w-1:0]           count_q, count_d;
  logic [hold_w-1:0]          hold_q;
  logic [err_cnt_width_p-1:0] err_cnt_q;
  logic                       wd_expired;

  // Occupancy follows the FIFO in every state; error recovery never corrects it.
  always_comb begin
    count_d = count_q;
    if (flush_i)                                  count_d = '0;
    else if (enq_i & ~deq_i & (count_q != full_lp)) count_d = count_q + 1'b1;
    else if (deq_i & ~enq_i & (count_q != '0))      count_d = count_q - 1'b1;
  end

`ifdef BSG_DFI_FIFO_MON_TIMEOUT_EN
  logic wd_active;

  assign wd_active = (state_q == ST_RUN) & (count_q != '0) & ~deq_i & ~flush_i;

  bsg_dfi_fifo_mon_watchdog #(
    .timeout_p (timeout_p)
  ) u_watchdog (
    .clk_i     (axi_clk_i),
    .reset_n_i (axi_reset_n_i),
    .active_i  (wd_active),
    .kick_i    (~wd_active),
    .expired_o (wd_expired)
  );
`else
  // Watchdog compiled out; the expression is constant false for any legal timeout_p.
  assign wd_expired = (timeout_p < 0);
`endif

  // Detection looks at pre-update occupancy; enq does not bypass an empty-FIFO pop.
  always_comb begin
    det_cause = CAUSE_NONE;
    if (!flush_i) begin
      if (enq_i & ~deq_i & (count_q == full_lp)) det_cause = CAUSE_OVERFLOW;
      else if (deq_i & (count_q == '0))          det_cause = CAUSE_UNDERFLOW;
      else if (wd_expired)                        det_cause = CAUSE_TIMEOUT;
    end
  end

  always_ff @(posedge axi_clk_i or negedge axi_reset_n_i) begin
    if (!axi_reset_n_i) begin
      state_q   <= ST_RUN;
      error_q   <= 1'b0;
      cause_q   <= CAUSE_NONE;
      err_cnt_q <= '0;
      hold_q    <= '0;
      count_q   <= '0;
    end else begin
      count_q <= count_d;
      unique case (state_q)
        ST_RUN: begin
          if (det_cause != CAUSE_NONE) begin
            state_q <= ST_ERROR;
            error_q <= 1'b1;
            cause_q <= det_cause;
            if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
          end
        end
        ST_ERROR: begin
          if (clear_i) begin
            state_q <= ST_HOLDOFF;
            hold_q  <= hold_lp;
          end
        end
        ST_HOLDOFF: begin
          // Keep the flag up long enough for the DFI-side gate to sample it.
          if (hold_q == '0) begin
            state_q <= ST_RUN;
            error_q <= 1'b0;
            cause_q <= CAUSE_NONE;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign error_o   = error_q;
  assign cause_o   = cause_q;
  assign count_o   = count_q;
  assign err_cnt_o = err_cnt_q;

endmodule
